// File: rtl/result_fifo_ctrl.sv
// Circular-FIFO controller for the MSM result buffer, driving an external
// simple-dual-port SRAM with 1-cycle read latency.
module result_fifo_ctrl #(
    parameter int WIDTH_ID   = 2,
    parameter int WIDTH_DATA = 384,
    parameter int AW         = 5,
    parameter int AF_TH      = 28
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 w_req,
    input  logic [WIDTH_ID+3*WIDTH_DATA-1:0]     result_i,
    input  logic                                 r_req,
    output logic                                 mem_w_en,
    output logic [AW-1:0]                        mem_w_addr,
    output logic [WIDTH_ID+3*WIDTH_DATA-1:0]     mem_w_data,
    output logic                                 mem_r_en,
    output logic [AW-1:0]                        mem_r_addr,
    input  logic [WIDTH_ID+3*WIDTH_DATA-1:0]     mem_r_data,
    output logic [WIDTH_ID+3*WIDTH_DATA-1:0]     data_o,
    output logic                                 data_vld_o,
    output logic [WIDTH_ID-1:0]                  rb_id,
    output logic [AW:0]                          cnt_o,
    output logic                                 empty,
    output logic                                 full,
    output logic                                 almost_full,
    output logic                                 ovf_err,
    output logic                                 udf_err
);

    localparam int          W       = WIDTH_ID + 3*WIDTH_DATA;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(2**AW);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_TH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          r_vld;
    logic          r_ovf;
    logic          r_udf;

    logic          w_empty;
    logic          w_full;
    logic          w_r_acc;
    logic          w_w_acc;
    logic          w_ovf_set;
    logic          w_udf_set;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == DEPTH_C);
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign w_r_acc   = ~flush & r_req & ~w_empty;
    assign w_w_acc   = ~flush & w_req & (~w_full | w_r_acc);
    assign w_ovf_set = ~flush & w_req & w_full & ~w_r_acc;
    assign w_udf_set = ~flush & r_req & w_empty;

    assign mem_w_en    = w_w_acc;
    assign mem_w_addr  = r_wr_ptr;
    assign mem_w_data  = result_i;
    assign mem_r_en    = w_r_acc;
    assign mem_r_addr  = r_rd_ptr;
    assign data_o      = mem_r_data;
    assign rb_id       = mem_r_data[W-1 -: WIDTH_ID];
    assign data_vld_o  = r_vld;
    assign cnt_o       = r_cnt;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_cnt >= AF_C);
    assign ovf_err     = r_ovf;
    assign udf_err     = r_udf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_vld    <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_vld    <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_w_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_r_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_w_acc, w_r_acc})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
            r_vld <= w_r_acc;
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_udf_set) r_udf <= 1'b1;
        end
    end

endmodule

// File: doc/result_fifo_ctrl.md
Name: result_fifo_ctrl

Overview:
Parametrised controller for the MSM result buffer. It drives an external simple-dual-port SRAM (one write port, one read port, 1-cycle read latency) as a circular FIFO of {id, X, Y, Z} result words. It generalises the buffer to configurable depth and data width. It adds true full/empty protection, an occupancy count, an almost-full threshold, a synchronous flush, a read-data-valid strobe and sticky overflow/underflow error flags. It sits between the MSM result path (writer) and the MSM/bucket consumer (reader).

Parameters:
WIDTH_ID, 2, width of the result ID field (MSBs of each word)
WIDTH_DATA, 384, width of one coordinate; word width W = WIDTH_ID + 3*WIDTH_DATA
AW, 5, address width; DEPTH = 2**AW entries
AF_TH, 28, almost-full threshold; must satisfy 1 <= AF_TH <= DEPTH

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of pointers, count and error flags
w_req  in  1  write request; result_i is presented this cycle
result_i  in  W  result word from MSM
r_req  in  1  read request
mem_w_en  out  1  SRAM write enable (= accepted write)
mem_w_addr  out  AW  SRAM write address
mem_w_data  out  W  SRAM write data (= result_i)
mem_r_en  out  1  SRAM read enable (= accepted read)
mem_r_addr  out  AW  SRAM read address
mem_r_data  in  W  SRAM read data, valid the cycle after mem_r_en
data_o  out  W  read data to consumer (= mem_r_data)
data_vld_o  out  1  data_o valid strobe
rb_id  out  WIDTH_ID  data_o[W-1 -: WIDTH_ID]
cnt_o  out  AW+1  occupancy, 0..DEPTH
empty  out  1  cnt_o == 0
full  out  1  cnt_o == DEPTH
almost_full  out  1  cnt_o >= AF_TH
ovf_err  out  1  sticky: write requested while full and no read was accepted that cycle
udf_err  out  1  sticky: read requested while empty

Behaviour:
- Reset (async, rst_n=0): wr_ptr, rd_ptr, cnt = 0; data_vld_o, ovf_err, udf_err = 0. Consequently empty=1, full=0, almost_full=0.
- Acceptance, evaluated on the pre-edge state:
  - r_acc = r_req & !empty
  - w_acc = w_req & (!full | r_acc)
- Write and read on the same cycle:
  - When empty: the write is accepted and the read is rejected. There is no bypass.
  - When full: both are accepted and cnt is unchanged.
- mem_w_en = w_acc and mem_r_en = r_acc, both combinational. The addresses are the current wr_ptr/rd_ptr, also combinational.
- Pointers: wr_ptr += 1 on w_acc and rd_ptr += 1 on r_acc. Each wraps modulo DEPTH (natural AW-bit rollover, DEPTH-1 -> 0).
- cnt: +1 on w_acc only, -1 on r_acc only, unchanged on both or neither. cnt never leaves 0..DEPTH.
- Read latency: data_vld_o is registered and equals r_acc delayed 1 cycle. data_o/rb_id pass through mem_r_data combinationally and are meaningful only while data_vld_o=1.
- Flags empty/full/almost_full are combinational from cnt. Each word occupies exactly one entry, so status and pointers stay consistent.
- Errors:
  - ovf_err sets on (w_req & full & !r_acc). The rejected write is dropped: no mem_w_en, no state change.
  - udf_err sets on (r_req & empty). No mem_r_en and no data_vld_o.
  - Both flags stay set until flush or reset.
- flush (sync, highest priority after reset):
  - Next cycle pointers, cnt, ovf_err, udf_err = 0 and data_vld_o = 0.
  - Requests in the flush cycle are ignored: mem_w_en = mem_r_en = 0 while flush=1.
- Reset mid-operation: all state is cleared immediately and asynchronously. SRAM contents are not cleared and are unreachable after reset.

Test Plan:
- Reset, then AW=2 (DEPTH=4), AF_TH=3: write IDs 0,1,2,3 on 4 consecutive cycles. Expect mem_w_addr 0,1,2,3. almost_full rises when cnt_o=3; full=1 and cnt_o=4 after the 4th write.
- Full, w_req=1 with r_req=0 -> no mem_w_en, ovf_err=1 and stays set. Full with w_req=r_req=1 -> both accepted, cnt_o stays 4, wr_ptr and rd_ptr wrap to 1.
- From 4 entries, read 4 times back-to-back: mem_r_addr 0..3, data_vld_o on the following cycles, rb_id = 0,1,2,3 in order, empty=1 after the last read.
- Empty, w_req=r_req=1 -> write accepted, read rejected, udf_err=1, cnt_o=1, no data_vld_o.
- Wrap stress: 10 writes interleaved with 10 reads, random gaps, occupancy kept at 3 or below. Every word is returned in order and cnt_o always equals writes minus reads.
- Mid-traffic, assert flush with w_req=1 -> no mem_w_en that cycle. Next cycle cnt_o=0, empty=1, errors cleared. Repeat with rst_n pulled low mid-burst -> the same values appear asynchronously.
